// File: rtl/bk_add_arbiter.sv
// Shared 32-bit Brent-Kung adder with round-robin arbitration among N_REQ requesters.
// Registered operands, multicycle settle, valid/ready result and per-requester carry store.

module bruntkung_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    localparam int unsigned W    = 32;
    localparam int unsigned LVLS = 5;

    logic [W-1:0] h;
    logic [W-1:0] g;
    logic [W-1:0] p;

    // Carry-in is folded into bit 0's generate, so prefix G terms are absolute carries.
    always_comb begin
        h    = a ^ b;
        g    = a & b;
        p    = h;
        g[0] = g[0] | (h[0] & cin);
        p[0] = 1'b0;
        for (int l = 1; l <= int'(LVLS); l++) begin
            for (int i = (1 << l) - 1; i < int'(W); i += (1 << l)) begin
                g[i] = g[i] | (p[i] & g[i - (1 << (l - 1))]);
                p[i] = p[i] & p[i - (1 << (l - 1))];
            end
        end
        for (int l = int'(LVLS) - 1; l >= 1; l--) begin
            for (int i = (1 << l) + (1 << (l - 1)) - 1; i < int'(W); i += (1 << l)) begin
                g[i] = g[i] | (p[i] & g[i - (1 << (l - 1))]);
                p[i] = p[i] & p[i - (1 << (l - 1))];
            end
        end
    end

    assign sum  = h ^ {g[W-2:0], cin};
    assign cout = g[W-1];
endmodule

module bk_add_arbiter #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [32*N_REQ-1:0] a_in,
    input  logic [32*N_REQ-1:0] b_in,
    input  logic [N_REQ-1:0]    cin_in,
    input  logic [N_REQ-1:0]    chain,
    output logic [N_REQ-1:0]    gnt,
    output logic                busy,
    output logic                rsp_valid,
    output logic [2:0]          rsp_id,
    output logic [31:0]         rsp_sum,
    output logic                rsp_cout,
    input  logic                rsp_ready
);
    localparam int unsigned DW    = 32;
    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = 4;
    localparam logic [IDX_W:0]   N_REQ_V  = (IDX_W + 1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    a_q, a_d;
    logic [DW-1:0]    b_q, b_d;
    logic             cin_q, cin_d;
    logic [IDX_W-1:0] id_q, id_d;
    logic [N_REQ-1:0] cstore_q, cstore_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [2:0]       rsp_id_q, rsp_id_d;
    logic [DW-1:0]    rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;

    logic [DW-1:0]    a_arr [N_REQ];
    logic [DW-1:0]    b_arr [N_REQ];
    logic             found_c;
    logic [IDX_W-1:0] win_c;
    logic [IDX_W:0]   scan_idx;
    logic [DW-1:0]    add_sum;
    logic             add_cout;

    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_unpack
        assign a_arr[i] = a_in[DW*i +: DW];
        assign b_arr[i] = b_in[DW*i +: DW];
    end

    // Round-robin search starting at ptr_q, wrapping past N_REQ-1.
    always_comb begin
        found_c  = 1'b0;
        win_c    = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (scan_idx >= N_REQ_V) begin
                scan_idx = scan_idx - N_REQ_V;
            end
            if (!found_c && req[scan_idx[IDX_W-1:0]]) begin
                found_c = 1'b1;
                win_c   = scan_idx[IDX_W-1:0];
            end
        end
    end

    bruntkung_adder u_adder (
        .a    (a_q),
        .b    (b_q),
        .cin  (cin_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        id_d        = id_q;
        cstore_d    = cstore_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        unique case (state_q)
            IDLE: begin
                if (found_c) begin
                    a_d     = a_arr[win_c];
                    b_d     = b_arr[win_c];
                    cin_d   = chain[win_c] ? cstore_q[win_c] : cin_in[win_c];
                    id_d    = win_c;
                    ptr_d   = (win_c == LAST_IDX) ? '0 : win_c + IDX_W'(1);
                    cnt_d   = CNT_INIT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_sum_d      = add_sum;
                    rsp_cout_d     = add_cout;
                    rsp_id_d       = 3'(id_q);
                    rsp_valid_d    = 1'b1;
                    cstore_d[id_q] = add_cout;
                    state_d        = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            id_q        <= '0;
            cstore_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            id_q        <= id_d;
            cstore_q    <= cstore_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    // Grant is the capture strobe itself, so it is suppressed while reset is applied.
    assign gnt       = (rst_n && state_q == IDLE && found_c) ? (N_REQ'(1) << win_c) : '0;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
endmodule

// File: tb/tb_bk_add_arbiter.sv
// Bench for bk_add_arbiter: directed scenarios plus random traffic, checked by a
// scoreboard whose expectations come from an arbitration/arithmetic model.

module tb_bk_add_arbiter;
    localparam int N  = 2;
    localparam int SC = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [32*N-1:0] a_in;
    logic [32*N-1:0] b_in;
    logic [N-1:0]    cin_in;
    logic [N-1:0]    chain;
    logic [N-1:0]    gnt;
    logic            busy;
    logic            rsp_valid;
    logic [2:0]      rsp_id;
    logic [31:0]     rsp_sum;
    logic            rsp_cout;
    logic            rsp_ready;

    always #5 clk = ~clk;

    bk_add_arbiter #(.N_REQ(N), .SETTLE_CYC(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin_in    (cin_in),
        .chain     (chain),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ready (rsp_ready)
    );

    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        cout;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        exp_q[$];
    int          m_ptr = 0;
    logic [N-1:0] m_cstore = '0;
    bit          m_idle = 1'b1;
    int          cyc = 0;
    int          grant_cyc = 0;
    bit          seen_valid = 1'b0;
    int          hs_cnt = 0;
    int          last_id = 0;
    logic [31:0] last_sum = '0;
    logic        last_cout = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Scoreboard: predicted grants push expected results; presented results are popped and compared.
    always @(negedge clk) begin
        int           w;
        logic [N-1:0] exp_gnt;
        logic         c;
        logic [32:0]  full;
        exp_t         e;
        if (!rst_n) begin
            chk("gnt_in_reset", 64'(gnt), 64'd0);
            exp_q.delete();
            m_ptr = 0; m_cstore = '0; m_idle = 1'b1; seen_valid = 1'b0;
        end else begin
            w = m_idle ? pick(req, m_ptr) : -1;
            exp_gnt = '0;
            if (w >= 0) exp_gnt[w] = 1'b1;
            chk("gnt", 64'(gnt), 64'(exp_gnt));
            chk("busy", 64'(busy), 64'(!m_idle));
            if (w >= 0) begin
                c    = chain[w] ? m_cstore[w] : cin_in[w];
                full = {1'b0, a_in[32*w +: 32]} + {1'b0, b_in[32*w +: 32]} + {32'd0, c};
                e.id = w; e.sum = full[31:0]; e.cout = full[32];
                exp_q.push_back(e);
                m_cstore[w] = full[32];
                m_ptr = (w + 1) % N;
                m_idle = 1'b0;
                grant_cyc = cyc;
                seen_valid = 1'b0;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_rsp: rsp_valid=1 id=%0d with nothing outstanding", rsp_id);
                end else begin
                    if (!seen_valid) begin
                        chk("latency", 64'(cyc - grant_cyc), 64'(SC + 1));
                        seen_valid = 1'b1;
                    end
                    chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
                    chk("rsp_sum", 64'(rsp_sum), 64'(exp_q[0].sum));
                    chk("rsp_cout", 64'(rsp_cout), 64'(exp_q[0].cout));
                    if (rsp_ready) begin
                        last_id = exp_q[0].id; last_sum = rsp_sum; last_cout = rsp_cout;
                        hs_cnt++;
                        void'(exp_q.pop_front());
                        m_idle = 1'b1;
                    end
                end
            end else if (!m_idle && !seen_valid && (cyc - grant_cyc) > SC + 1) begin
                total++; bad++;
                $display("FAIL missing_rsp: no rsp_valid %0d cycles after grant", cyc - grant_cyc);
                seen_valid = 1'b1;
            end
            cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic ch);
        a_in[32*i +: 32] = a;
        b_in[32*i +: 32] = b;
        cin_in[i] = ci;
        chain[i]  = ch;
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic ch);
        set_op(i, a, b, ci, ch);
        req[i] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (gnt[i]) begin
                step(1);
                req[i] = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        total++; bad++;
        $display("FAIL issue_timeout: requester %0d never granted", i);
        req[i] = 1'b0;
    endtask

    task automatic wait_hs(input int n0);
        for (int k = 0; k < 200; k++) begin
            if (hs_cnt > n0) return;
            step(1);
        end
        total++; bad++;
        $display("FAIL hs_timeout: handshake count %0d not above %0d", hs_cnt, n0);
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    logic [N-1:0] rr_exp [4];
    int           h;
    int           k;

    initial begin
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst_n = 1'b0; req = 2'b11; a_in = '0; b_in = '0; cin_in = '0; chain = '0; rsp_ready = 1'b1;

        // T1: reset with requests pending
        step(2);
        chk("t1_gnt", 64'(gnt), 64'd0);
        chk("t1_valid", 64'(rsp_valid), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_sum", 64'(rsp_sum), 64'd0);
        req = '0;
        rst_n = 1'b1;
        step(1);

        // T2: single op with carry out of bit 31
        h = hs_cnt;
        issue(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        wait_hs(h);
        chk("t2_id", 64'(last_id), 64'd0);
        chk("t2_sum", 64'(last_sum), 64'd0);
        chk("t2_cout", 64'(last_cout), 64'd1);

        // T3: round robin from a fresh pointer
        rst_pulse();
        h = hs_cnt;
        set_op(0, $urandom, $urandom, 1'b0, 1'b0);
        set_op(1, $urandom, $urandom, 1'b1, 1'b0);
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            k = 0;
            #1;
            while (gnt == '0 && k < 50) begin
                step(1); #1; k++;
            end
            chk($sformatf("t3_gnt%0d", g), 64'(gnt), 64'(rr_exp[g]));
            step(1);
        end
        req = '0;
        wait_hs(h + 3);

        // T4: 64-bit chained add on requester 1 with requester 0 interleaved
        rst_pulse();
        h = hs_cnt;
        issue(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        wait_hs(h);
        chk("t4_lo_sum", 64'(last_sum), 64'd0);
        chk("t4_lo_cout", 64'(last_cout), 64'd1);
        h = hs_cnt;
        issue(0, $urandom, $urandom, 1'b1, 1'b1);
        wait_hs(h);
        h = hs_cnt;
        issue(1, 32'd1, 32'd2, 1'b0, 1'b1);
        wait_hs(h);
        chk("t4_hi_id", 64'(last_id), 64'd1);
        chk("t4_hi_sum", 64'(last_sum), 64'd4);
        chk("t4_hi_cout", 64'(last_cout), 64'd0);

        // T5: stalled response blocks new grants
        rsp_ready = 1'b0;
        issue(0, $urandom, $urandom, 1'b0, 1'b0);
        k = 0;
        while (!rsp_valid && k < 20) begin step(1); k++; end
        chk("t5_valid", 64'(rsp_valid), 64'd1);
        set_op(1, $urandom, $urandom, 1'b1, 1'b0);
        req[1] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            #1;
            chk("t5_gnt_stall", 64'(gnt), 64'd0);
            step(1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("t5_gnt_hs", 64'(gnt), 64'd0);
        step(1);
        chk("t5_gnt_idle", 64'(gnt), 64'(2'b10));
        h = hs_cnt;
        step(1);
        req[1] = 1'b0;
        wait_hs(h);

        // T6: reset during settle discards the op and its carry
        issue(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk("t6_no_valid", 64'(rsp_valid), 64'd0);
            step(1);
        end
        h = hs_cnt;
        issue(1, 32'd1, 32'd1, 1'b1, 1'b1);
        wait_hs(h);
        chk("t6_sum", 64'(last_sum), 64'd2);
        chk("t6_cout", 64'(last_cout), 64'd0);

        // Random traffic with random backpressure
        for (int c = 0; c < 600; c++) begin
            req = N'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                set_op(i, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom,
                       1'($urandom), 1'($urandom));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        req = '0;
        rsp_ready = 1'b1;
        step(2 * SC + 10);
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
